// File: rtl/squeeze_output_streamer.sv
// ============================================================================
//  Module      : squeeze_output_streamer
//  Description : Squeeze-side streamer for the SHAKE core. Emits the rate part
//                of the Keccak state as W-bit words, masking the final partial
//                word and requesting further permutations as needed.
//                Optional feature macro: OUT_BYTE_KEEP_EN (adds keep_o).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module squeeze_output_streamer #(
    parameter int W              = 64,
    parameter int LEN_WIDTH      = 32,
    parameter int MAX_RATE_WORDS = 21
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [LEN_WIDTH-1:0]          out_len_i,
    input  logic [10:0]                   block_size_i,
    input  logic [MAX_RATE_WORDS*W-1:0]   block_i,
    input  logic                          block_valid_i,
    output logic                          block_ready_o,
    output logic                          perm_req_o,
    output logic [W-1:0]                  data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          last_o,
`ifdef OUT_BYTE_KEEP_EN
    output logic [W/8-1:0]                keep_o,
`endif
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int c_rw_w = $clog2(MAX_RATE_WORDS + 1);
    localparam int c_sh_w = (W > 1) ? $clog2(W) : 1;
    localparam logic [LEN_WIDTH-1:0] c_w_len = LEN_WIDTH'(W);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_BLK = 2'd1,
        S_STREAM   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic [c_rw_w-1:0]      r_rate;
    logic [c_rw_w-1:0]      r_idx;
    logic [W-1:0]           r_blk [MAX_RATE_WORDS];
    logic                   r_block_ready;
    logic                   r_perm_req;
    logic                   r_valid;
    logic                   r_last;
    logic                   r_busy;
    logic                   r_done;

    logic [10:0]            w_bs_words;
    logic [c_rw_w-1:0]      w_rate;
    logic [W-1:0]           w_mask;
    logic                   w_capture;
    logic [LEN_WIDTH-1:0]   w_rem_next;

    // Rate in words, clamped to [1, MAX_RATE_WORDS].
    assign w_bs_words = block_size_i / 11'(W);
    assign w_rate     = (w_bs_words > 11'(MAX_RATE_WORDS)) ? c_rw_w'(MAX_RATE_WORDS) :
                        (w_bs_words == 11'd0)              ? c_rw_w'(1) :
                                                             w_bs_words[c_rw_w-1:0];

    assign w_capture  = (r_state == S_WAIT_BLK) && block_valid_i;
    assign w_rem_next = (r_remaining > c_w_len) ? (r_remaining - c_w_len) : '0;

    // Below one word remaining, only the low 'remaining' bits survive.
    assign w_mask = (r_remaining >= c_w_len) ? {W{1'b1}}
                                             : ~({W{1'b1}} << r_remaining[c_sh_w-1:0]);

    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < MAX_RATE_WORDS; k++) begin
                r_blk[k] <= block_i[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_remaining   <= '0;
            r_rate        <= '0;
            r_idx         <= '0;
            r_block_ready <= 1'b0;
            r_perm_req    <= 1'b0;
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_perm_req <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (out_len_i == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_remaining   <= out_len_i;
                            r_rate        <= w_rate;
                            r_state       <= S_WAIT_BLK;
                            r_block_ready <= 1'b1;
                            r_busy        <= 1'b1;
                        end
                    end
                end
                S_WAIT_BLK: begin
                    if (block_valid_i) begin
                        r_idx         <= '0;
                        r_state       <= S_STREAM;
                        r_block_ready <= 1'b0;
                        r_valid       <= 1'b1;
                        r_last        <= (r_remaining <= c_w_len);
                    end
                end
                S_STREAM: begin
                    if (ready_i) begin
                        r_remaining <= w_rem_next;
                        if (r_last) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_idx == r_rate - 1'b1) begin
                            // Rate block exhausted with output still owed.
                            r_state       <= S_WAIT_BLK;
                            r_valid       <= 1'b0;
                            r_block_ready <= 1'b1;
                            r_perm_req    <= 1'b1;
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                            r_last <= (w_rem_next <= c_w_len);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign block_ready_o = r_block_ready;
    assign perm_req_o    = r_perm_req;
    assign valid_o       = r_valid;
    assign last_o        = r_last;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign data_o        = r_valid ? (r_blk[r_idx] & w_mask) : '0;

`ifdef OUT_BYTE_KEEP_EN
    // A byte is kept if any of its bits is still owed, so a partial byte counts.
    for (genvar b = 0; b < W/8; b++) begin : g_keep
        assign keep_o[b] = r_valid & (r_remaining > LEN_WIDTH'(b*8));
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_squeeze_output_streamer.sv
// ============================================================================
//  Module      : tb_squeeze_output_streamer
//  Description : Directed self-checking bench for squeeze_output_streamer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_squeeze_output_streamer;

    localparam int W   = 64;
    localparam int LW  = 32;
    localparam int MRW = 21;

    logic              clk;
    logic              rst;
    logic              start_i;
    logic [LW-1:0]     out_len_i;
    logic [10:0]       block_size_i;
    logic [MRW*W-1:0]  block_i;
    logic              block_valid_i;
    logic              block_ready_o;
    logic              perm_req_o;
    logic [W-1:0]      data_o;
    logic              valid_o;
    logic              ready_i;
    logic              last_o;
    logic              busy_o;
    logic              done_o;
`ifdef OUT_BYTE_KEEP_EN
    logic [W/8-1:0]    keep_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    squeeze_output_streamer #(
        .W              (W),
        .LEN_WIDTH      (LW),
        .MAX_RATE_WORDS (MRW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .out_len_i     (out_len_i),
        .block_size_i  (block_size_i),
        .block_i       (block_i),
        .block_valid_i (block_valid_i),
        .block_ready_o (block_ready_o),
        .perm_req_o    (perm_req_o),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .last_o        (last_o),
`ifdef OUT_BYTE_KEEP_EN
        .keep_o        (keep_o),
`endif
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int b, input int k);
        return {8'hC0 + 8'(b), 8'(k), 16'hBEEF, 32'h0123_4567 + 32'(k)};
    endfunction

    function automatic logic [MRW*W-1:0] make_block(input int b);
        logic [MRW*W-1:0] v;
        v = '0;
        for (int k = 0; k < MRW; k++) v[k*64 +: 64] = pat(b, k);
        return v;
    endfunction

    function automatic logic [63:0] mask_of(input int rem);
        logic [63:0] one;
        one = 64'h1;
        return (rem >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((one << rem) - 64'h1);
    endfunction

    task automatic check_word(input int b, input int k, input int rem);
        check($sformatf("valid b%0d w%0d", b, k), 64'(valid_o), 64'h1);
        check($sformatf("data b%0d w%0d", b, k), data_o, pat(b, k) & mask_of(rem));
        check($sformatf("last b%0d w%0d", b, k), 64'(last_o), 64'(rem <= 64));
`ifdef OUT_BYTE_KEEP_EN
        begin
            logic [7:0] ek;
            for (int i = 0; i < 8; i++) ek[i] = (i * 8 < rem);
            check($sformatf("keep b%0d w%0d", b, k), 64'(keep_o), 64'(ek));
        end
`endif
    endtask

    // One complete squeeze; stall_k stalls that word of the first block for 3 cycles.
    task automatic run_txn(input int len, input int bs, input int stall_k);
        int  rate;
        int  rem;
        int  blk;
        int  k;
        bit  fin;
        rate = bs / 64;
        rem  = len;
        blk  = 0;
        fin  = 1'b0;
        @(negedge clk);
        start_i = 1'b1; out_len_i = LW'(len); block_size_i = 11'(bs);
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", 64'(busy_o), 64'h1);
        check("no_valid_before_blk", 64'(valid_o), 64'h0);
        while (!fin) begin
            check($sformatf("blk_ready b%0d", blk), 64'(block_ready_o), 64'h1);
            block_i = make_block(blk);
            block_valid_i = 1'b1;
            @(negedge clk);
            block_valid_i = 1'b0;
            check($sformatf("blk_ready_low b%0d", blk), 64'(block_ready_o), 64'h0);
            k = 0;
            while (!fin && k < rate) begin
                check_word(blk, k, rem);
                if (k == stall_k && blk == 0) begin
                    ready_i = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        check_word(blk, k, rem);
                    end
                    ready_i = 1'b1;
                end
                @(negedge clk);
                rem -= (rem < 64) ? rem : 64;
                if (rem == 0) begin
                    check("done_pulse", 64'(done_o), 64'h1);
                    check("valid_after_last", 64'(valid_o), 64'h0);
                    check("perm_after_last", 64'(perm_req_o), 64'h0);
                    check("busy_after_last", 64'(busy_o), 64'h0);
                    fin = 1'b1;
                    @(negedge clk);
                    check("done_one_cycle", 64'(done_o), 64'h0);
                end else if (k == rate - 1) begin
                    check($sformatf("perm_req b%0d", blk), 64'(perm_req_o), 64'h1);
                    check($sformatf("valid_gap b%0d", blk), 64'(valid_o), 64'h0);
                    blk++;
                end else begin
                    check($sformatf("no_perm b%0d w%0d", blk, k), 64'(perm_req_o), 64'h0);
                    check($sformatf("no_done b%0d w%0d", blk, k), 64'(done_o), 64'h0);
                end
                k++;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(valid_o), 64'h0);
        check({tag, "_data"}, data_o, 64'h0);
        check({tag, "_last"}, 64'(last_o), 64'h0);
        check({tag, "_busy"}, 64'(busy_o), 64'h0);
        check({tag, "_done"}, 64'(done_o), 64'h0);
        check({tag, "_perm"}, 64'(perm_req_o), 64'h0);
        check({tag, "_bready"}, 64'(block_ready_o), 64'h0);
`ifdef OUT_BYTE_KEEP_EN
        check({tag, "_keep"}, 64'(keep_o), 64'h0);
`endif
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; out_len_i = '0; block_size_i = '0;
        block_i = '0; block_valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_txn(256, 1344, -1);    // 4 words, no permutation request
        run_txn(100, 1344, -1);    // second word masked to 36 bits
        run_txn(1408, 1344, -1);   // 21 words, perm request, 1 more word
        run_txn(640, 1344, 2);     // stall on word 3
        run_txn(2176, 1088, -1);   // two full 17-word blocks

        // Reset in the middle of a stream.
        @(negedge clk);
        start_i = 1'b1; out_len_i = 32'd1000; block_size_i = 11'd1344;
        @(negedge clk);
        start_i = 1'b0;
        block_i = make_block(5); block_valid_i = 1'b1;
        @(negedge clk);
        block_valid_i = 1'b0;
        check("pre_reset_valid", 64'(valid_o), 64'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midreset");

        // Zero-length request: done only.
        start_i = 1'b1; out_len_i = '0; block_size_i = 11'd1344;
        @(negedge clk);
        start_i = 1'b0;
        check("len0_done", 64'(done_o), 64'h1);
        check("len0_valid", 64'(valid_o), 64'h0);
        check("len0_busy", 64'(busy_o), 64'h0);
        @(negedge clk);
        check("len0_done_low", 64'(done_o), 64'h0);
        check("len0_valid_after", 64'(valid_o), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
